state_machine: RTL and testbench
================================

STATE_MACHINE -- requirements
Module: state_machine

Interface
REQ-001 The module SHALL have parameter MAX_DIGITS, default 4, giving the maximum digits accepted per operand (range 1..7).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port key, input, 5 bits: keypad code.
- 0x00..0x09 = digits 0..9
- 0x0A/0x0B/0x0C = operators A/B/C
- 0x0D = D (execute)
- 0x0E = E (clear)
- 0x0F = F (no function)
- any code with key[4]=1 = no key (KEY_NONE, canonical 0x10)
REQ-005 The module SHALL have port end_obl, input, 1 bit: level signal from the arithmetic unit meaning the calculation has finished.
REQ-006 The module SHALL have port ST, output, 2 bits: main state.
- 00 ARG1
- 01 ARG2
- 10 CALC
- 11 RESULT
REQ-007 The module SHALL have port ST_L, output, 3 bits: count of digits entered into the current operand.

Function
REQ-008 The module SHALL register the previous key sample (key_prev) every clock.
REQ-009 A press event SHALL occur on a rising edge only when the current key is a real key (key[4]=0) and key_prev was a no-key code.
REQ-010 A key held for many cycles SHALL produce exactly one press event; no debouncing beyond this SHALL be performed.
REQ-011 ST and ST_L SHALL be registered outputs that update on the same rising edge as the press event or end_obl sample (latency 1 edge, no combinational path to outputs).
REQ-012 In ARG1 or ARG2, a digit press SHALL increment ST_L if ST_L < MAX_DIGITS; otherwise it SHALL be ignored (saturate).
REQ-013 In ARG1, an A/B/C press with ST_L >= 1 SHALL move to ARG2 with ST_L=0; with ST_L=0 it SHALL be ignored.
REQ-014 In ARG2, a D press with ST_L >= 1 SHALL move to CALC with ST_L held; with ST_L=0 it SHALL be ignored.
REQ-015 In ARG2, A/B/C presses SHALL be ignored.
REQ-016 In ARG1, D presses SHALL be ignored.
REQ-017 In CALC, all key presses including E SHALL be ignored.
REQ-018 In CALC, end_obl=1 sampled at a rising edge SHALL move to RESULT with ST_L=0.
REQ-019 In RESULT, a digit press SHALL move to ARG1 with ST_L=1, starting a new first operand.
REQ-020 In RESULT, A/B/C/D presses SHALL be ignored.
REQ-021 An E press in ARG1, ARG2 or RESULT SHALL move to ARG1 with ST_L=0.
REQ-022 An F press SHALL be ignored in every state.
REQ-023 end_obl SHALL be ignored in every state except CALC; if it is already high on entry to CALC, the move to RESULT SHALL occur on the next edge.
REQ-024 If a no-key code and end_obl arrive together, only end_obl SHALL be acted on, and only in CALC.
REQ-025 ST_L SHALL never exceed MAX_DIGITS.
REQ-026 Only the four ST encodings SHALL be reachable.

Reset
REQ-027 While rst=1, the module SHALL asynchronously force ST=00 (ARG1), ST_L=0 and key_prev=KEY_NONE, regardless of the clock.
REQ-028 After rst deasserts, a key already held SHALL count as a press at the first rising edge.
REQ-029 Reset asserted in any state, including mid-CALC, SHALL abort to ARG1/0 immediately.

Verification
REQ-030 Basic flow, each key held 5 clocks then KEY_NONE for 5 clocks:
- rst 1->0, then key 2 -> ST=00, ST_L=1
- key A -> ST=01, ST_L=0
- key 4 -> ST=01, ST_L=1
- key D -> ST=10, ST_L=1
- end_obl=1 -> ST=11, ST_L=0 on the next edge
REQ-031 Held key: key 7 held 20 clocks from ARG1/0 -> ST_L=1 only.
REQ-032 Digit saturation: 6 separate digit presses with MAX_DIGITS=4 -> ST_L=4.
REQ-033 Ignored keys: A press in ARG1 with ST_L=0 -> no change; D press in ARG2 with ST_L=0 -> no change.
REQ-034 CALC lock and clear: in CALC, press E -> ST stays 10; after end_obl -> RESULT; then E -> ARG1/0; alternatively digit 5 in RESULT -> ARG1/1.
REQ-035 Reset and stray end_obl: rst pulse mid-cycle while in CALC -> ST=00, ST_L=0 immediately without a clock edge; end_obl=1 while in ARG1 -> no change.

Source files
------------

// File: rtl/state_machine.sv
// Keypad-driven calculator front end: collects two operands, waits for the
// arithmetic unit during CALC, then shows RESULT until a new digit or clear.
module state_machine #(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key,
  input  logic       end_obl,
  output logic [1:0] ST,
  output logic [2:0] ST_L
);

  typedef enum logic [1:0] {
    ST_ARG1   = 2'b00,
    ST_ARG2   = 2'b01,
    ST_CALC   = 2'b10,
    ST_RESULT = 2'b11
  } st_e;

  localparam logic [4:0] KEY_NONE = 5'h10;
  localparam logic [2:0] MAX_L    = 3'(MAX_DIGITS);

  st_e        st_q, st_d;
  logic [2:0] st_l_q, st_l_d;
  logic [4:0] key_prev_q;

  logic press;
  logic is_digit, is_op, is_exec, is_clear;

  // A press is a real key whose previous sample was "no key"; holding a key
  // therefore yields exactly one event.
  assign press    = !key[4] && key_prev_q[4];
  assign is_digit = (key[3:0] <= 4'd9);
  assign is_op    = (key[3:0] >= 4'hA) && (key[3:0] <= 4'hC);
  assign is_exec  = (key[3:0] == 4'hD);
  assign is_clear = (key[3:0] == 4'hE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_ARG1;
      st_l_q     <= 3'd0;
      key_prev_q <= KEY_NONE;
    end else begin
      st_q       <= st_d;
      st_l_q     <= st_l_d;
      key_prev_q <= key;
    end
  end

  always_comb begin
    st_d   = st_q;
    st_l_d = st_l_q;
    case (st_q)
      ST_ARG1, ST_ARG2: begin
        if (press) begin
          if (is_digit) begin
            if (st_l_q < MAX_L) st_l_d = st_l_q + 3'd1;
          end else if (is_op) begin
            if (st_q == ST_ARG1 && st_l_q != 3'd0) begin
              st_d   = ST_ARG2;
              st_l_d = 3'd0;
            end
          end else if (is_exec) begin
            // Operand length stays visible while the arithmetic unit works.
            if (st_q == ST_ARG2 && st_l_q != 3'd0) st_d = ST_CALC;
          end else if (is_clear) begin
            st_d   = ST_ARG1;
            st_l_d = 3'd0;
          end
        end
      end
      ST_CALC: begin
        if (end_obl) begin
          st_d   = ST_RESULT;
          st_l_d = 3'd0;
        end
      end
      ST_RESULT: begin
        if (press) begin
          if (is_digit) begin
            st_d   = ST_ARG1;
            st_l_d = 3'd1;
          end else if (is_clear) begin
            st_d   = ST_ARG1;
            st_l_d = 3'd0;
          end
        end
      end
      default: begin
        st_d   = ST_ARG1;
        st_l_d = 3'd0;
      end
    endcase
  end

  assign ST   = st_q;
  assign ST_L = st_l_q;

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine: a behavioural calculator model is checked
// every cycle, and literal checkpoints pin both the model and the DUT.
module tb_state_machine;

  localparam int MAXD = 4;
  localparam int M_ARG1 = 0, M_ARG2 = 1, M_CALC = 2, M_RESULT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] key = 5'h10;
  logic       end_obl = 1'b0;
  logic [1:0] ST;
  logic [2:0] ST_L;

  int n_vec = 0;
  int n_err = 0;

  int m_mode = M_ARG1;
  int m_cnt = 0;
  bit m_prev_none = 1'b1;

  state_machine #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .key(key), .end_obl(end_obl), .ST(ST), .ST_L(ST_L)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic void m_reset();
    m_mode = M_ARG1;
    m_cnt = 0;
    m_prev_none = 1'b1;
  endfunction

  function automatic void m_step(input logic [4:0] k, input logic eo);
    int  v;
    bit  pressed;
    v = int'(k);
    pressed = (v < 16) && m_prev_none;
    m_prev_none = (v >= 16);
    if (m_mode == M_CALC) begin
      if (eo) begin m_mode = M_RESULT; m_cnt = 0; end
    end else if (pressed) begin
      if (v == 14) begin
        m_mode = M_ARG1; m_cnt = 0;
      end else if (v <= 9) begin
        if (m_mode == M_RESULT) begin m_mode = M_ARG1; m_cnt = 1; end
        else if (m_cnt < MAXD) m_cnt = m_cnt + 1;
      end else if (v >= 10 && v <= 12) begin
        if (m_mode == M_ARG1 && m_cnt > 0) begin m_mode = M_ARG2; m_cnt = 0; end
      end else if (v == 13) begin
        if (m_mode == M_ARG2 && m_cnt > 0) m_mode = M_CALC;
      end
    end
  endfunction

  always @(posedge rst) m_reset();

  always @(posedge clk) begin
    if (rst) m_reset();
    else m_step(key, end_obl);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (int'(ST) != m_mode || int'(ST_L) != m_cnt) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t: ST=%0d ST_L=%0d, model ST=%0d ST_L=%0d",
                 $time, ST, ST_L, m_mode, m_cnt);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic check(input string name, input int exp_st, input int exp_l);
    n_vec++;
    if (m_mode != exp_st || m_cnt != exp_l) begin
      n_err++;
      $display("FAIL %s(model): got ST=%0d ST_L=%0d, expected ST=%0d ST_L=%0d",
               name, m_mode, m_cnt, exp_st, exp_l);
    end
    n_vec++;
    if (int'(ST) != exp_st || int'(ST_L) != exp_l) begin
      n_err++;
      $display("FAIL %s: got ST=%0d ST_L=%0d, expected ST=%0d ST_L=%0d",
               name, ST, ST_L, exp_st, exp_l);
    end
  endtask

  task automatic press(input logic [4:0] k, input int hold = 5, input int gap = 5);
    @(negedge clk);
    key = k;
    repeat (hold) @(negedge clk);
    key = 5'h10;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic pulse_end_obl(input int cycles);
    @(negedge clk);
    end_obl = 1'b1;
    repeat (cycles) @(negedge clk);
    end_obl = 1'b0;
  endtask

  initial begin
    #1 check("reset_async", 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic flow
    press(5'h02); check("flow_digit", 0, 1);
    press(5'h0A); check("flow_op", 1, 0);
    press(5'h04); check("flow_arg2", 1, 1);
    press(5'h0D); check("flow_exec", 2, 1);
    @(negedge clk); end_obl = 1'b1;
    @(negedge clk); check("flow_end_obl", 3, 0);
    end_obl = 1'b0;
    press(5'h0A); check("result_ignore_A", 3, 0);
    press(5'h0D); check("result_ignore_D", 3, 0);
    press(5'h0E); check("result_clear", 0, 0);

    // held key and direct key-to-key change
    press(5'h07, 20, 5); check("held_key", 0, 1);
    @(negedge clk); key = 5'h01;
    @(negedge clk); key = 5'h02;
    @(negedge clk); key = 5'h10;
    @(negedge clk); check("key_to_key", 0, 2);

    // ignored keys and saturation
    press(5'h0E); press(5'h0A); check("op_empty_arg1", 0, 0);
    press(5'h0D); check("exec_in_arg1", 0, 0);
    for (int i = 0; i < 6; i++) press(5'(i + 3));
    check("saturate", 0, 4);
    press(5'h0F); check("f_ignored", 0, 4);
    press(5'h0B); check("op_to_arg2", 1, 0);
    press(5'h0D); check("exec_empty_arg2", 1, 0);
    press(5'h0C); check("op_in_arg2", 1, 0);
    press(5'h1F); check("nokey_alias", 1, 0);

    // CALC lock, then digit restarts from RESULT
    press(5'h09); press(5'h0D); check("calc_enter", 2, 1);
    press(5'h0E); check("calc_lock_E", 2, 1);
    press(5'h03); check("calc_lock_digit", 2, 1);
    pulse_end_obl(1); check("calc_done", 3, 0);
    press(5'h05); check("result_digit", 0, 1);

    // reset mid-CALC without a clock edge
    press(5'h0A); press(5'h01); press(5'h0D); check("calc_again", 2, 1);
    @(negedge clk); #2 rst = 1'b1;
    #1 check("reset_mid_calc", 0, 0);
    @(negedge clk); rst = 1'b0;
    pulse_end_obl(3); check("stray_end_obl", 0, 0);

    // key held across reset release counts as a press
    @(negedge clk); rst = 1'b1; key = 5'h03;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check("held_through_reset", 0, 1);
    key = 5'h10;
    repeat (3) @(negedge clk);

    // end_obl already high when CALC is entered
    press(5'h0A); press(5'h06);
    @(negedge clk); end_obl = 1'b1;
    @(negedge clk); check("end_obl_in_arg2", 1, 1);
    key = 5'h0D;
    @(negedge clk); check("calc_entry_hi", 2, 1);
    @(negedge clk); check("calc_exit_hi", 3, 0);
    key = 5'h10; end_obl = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
